// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer
//
// Fading colour sequencer for the on-chip RGB LED driver. One colour channel at a
// time fades in, holds at full brightness, fades out, then the active colour
// rotates 001 -> 010 -> 100 -> 001.
//
// Optional feature: define RGB_FADE_GAMMA_EN to apply a square-law gamma curve
// to the brightness level. This adds one register stage in the duty path.
//
// Parameters:
//   StepCycles - clock cycles per brightness step
//   HoldSteps  - steps spent at full brightness (>= 1)
//   PwmBits    - width of PWM counter and brightness level
//
// Ports:
//   clk_i        - system clock, rising edge
//   rst_ni       - synchronous active-low reset
//   en_i         - run request, level-sensitive
//   pwm_o        - registered PWM enables, bit0/1/2 -> RGB0PWM/RGB1PWM/RGB2PWM
//   busy_o       - high whenever the sequencer is not idle
//   cycle_done_o - one-cycle pulse at the end of each fade-out

module rgb_fade_sequencer #(
    parameter int unsigned StepCycles = 187_500,
    parameter int unsigned HoldSteps  = 256,
    parameter int unsigned PwmBits    = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic [2:0] pwm_o,
    output logic       busy_o,
    output logic       cycle_done_o
);

    localparam int unsigned PrescW = (StepCycles > 1) ? $clog2(StepCycles) : 1;
    localparam int unsigned HoldW  = (HoldSteps > 1) ? $clog2(HoldSteps) : 1;

    localparam logic [PrescW-1:0]  PrescMax = PrescW'(StepCycles - 1);
    localparam logic [HoldW-1:0]   HoldMax  = HoldW'(HoldSteps - 1);
    localparam logic [PwmBits-1:0] LevelMax = {PwmBits{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StFadeIn,
        StHold,
        StFadeOut
    } state_e;

    state_e               state_q, state_d;
    logic [PwmBits-1:0]   pwm_cnt_q;
    logic [PrescW-1:0]    presc_q, presc_d;
    logic [PwmBits-1:0]   level_q, level_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    logic [2:0]           rgb_q, rgb_d;
    logic [2:0]           pwm_q, pwm_d;
    logic                 cycle_done_q, cycle_done_d;
    logic                 tick;
    logic [PwmBits-1:0]   duty;

`ifdef RGB_FADE_GAMMA_EN
    // Square-law gamma: duty = level^2 >> PwmBits, registered to keep the
    // multiplier out of the comparator path.
    logic [2*PwmBits-1:0] level_sq;
    logic [PwmBits-1:0]   duty_q;

    assign level_sq = {{PwmBits{1'b0}}, level_q} * {{PwmBits{1'b0}}, level_q};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            duty_q <= '0;
        end else begin
            duty_q <= PwmBits'(level_sq >> PwmBits);
        end
    end

    assign duty = duty_q;
`else
    assign duty = level_q;
`endif

    // Prescaler only runs while a sequence is active so every fade-in starts
    // with a full step period.
    assign tick = (state_q != StIdle) && (presc_q == PrescMax);

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        hold_d       = hold_q;
        rgb_d        = rgb_q;
        cycle_done_d = 1'b0;

        if (state_q == StIdle || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PrescW'(1);
        end

        unique case (state_q)
            StIdle: begin
                level_d = '0;
                if (en_i) begin
                    state_d = StFadeIn;
                end
            end
            StFadeIn: begin
                if (tick) begin
                    if (level_q == LevelMax) begin
                        state_d = StHold;
                        hold_d  = '0;
                    end else begin
                        level_d = level_q + PwmBits'(1);
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    if (hold_q == HoldMax) begin
                        state_d = StFadeOut;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end
            end
            StFadeOut: begin
                if (tick) begin
                    if (level_q == '0) begin
                        // End of cycle: rotate colour; en_i is only sampled here
                        // and in idle, so a dropped request completes gracefully.
                        rgb_d        = {rgb_q[1:0], rgb_q[2]};
                        cycle_done_d = 1'b1;
                        state_d      = en_i ? StFadeIn : StIdle;
                    end else begin
                        level_d = level_q - PwmBits'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        pwm_d = rgb_q & {3{pwm_cnt_q < duty}};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            pwm_cnt_q    <= '0;
            presc_q      <= '0;
            level_q      <= '0;
            hold_q       <= '0;
            rgb_q        <= 3'b001;
            pwm_q        <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwm_cnt_q    <= pwm_cnt_q + PwmBits'(1);
            presc_q      <= presc_d;
            level_q      <= level_d;
            hold_q       <= hold_d;
            rgb_q        <= rgb_d;
            pwm_q        <= pwm_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign pwm_o        = pwm_q;
    assign busy_o       = (state_q != StIdle);
    assign cycle_done_o = cycle_done_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed testbench for rgb_fade_sequencer with StepCycles=4, HoldSteps=2,
// PwmBits=4. A second instance with a long hold measures full-brightness duty.

module tb_rgb_fade_sequencer;

    // One fade cycle = 4 * (16 + 2 + 16) clocks.
    localparam int unsigned CycleLen = 136;
`ifdef RGB_FADE_GAMMA_EN
    localparam int unsigned HoldDuty = 14;  // (15*15) >> 4
`else
    localparam int unsigned HoldDuty = 15;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] pwm;
    logic       busy;
    logic       cycle_done;

    logic       en_h;
    logic [2:0] pwm_h;
    logic       busy_h;
    logic       cycle_done_h;

    int unsigned n_checks;
    int unsigned n_errors;

    rgb_fade_sequencer #(
        .StepCycles (4),
        .HoldSteps  (2),
        .PwmBits    (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .pwm_o        (pwm),
        .busy_o       (busy),
        .cycle_done_o (cycle_done)
    );

    rgb_fade_sequencer #(
        .StepCycles (4),
        .HoldSteps  (16),
        .PwmBits    (4)
    ) u_hold (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en_h),
        .pwm_o        (pwm_h),
        .busy_o       (busy_h),
        .cycle_done_o (cycle_done_h)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until cycle_done is seen (bounded); report edges taken and OR of pwm.
    task automatic wait_pulse(output int unsigned edges, output logic [2:0] seen);
        edges = 0;
        seen  = '0;
        do begin
            step();
            edges++;
            seen |= pwm;
        end while (!cycle_done && edges < 400);
    endtask

    initial begin
        int unsigned edges;
        int unsigned cnt_pwm;
        int unsigned cnt_busy;
        int unsigned cnt_done;
        int unsigned cnt_hi;
        int unsigned cnt_other;
        logic [2:0]  seen;
        logic [2:0]  seen_pre;

        n_checks = 0;
        n_errors = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        en       = 1'b1;
        en_h     = 1'b0;

        // Reset held for three edges with en high.
        repeat (3) step();
        check_eq("rst_pwm", pwm, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cycle_done", cycle_done, 0);

        rst_n = 1'b1;
        step();
        check_eq("busy_after_rst", busy, 1);

        // Cycle 1: 137 edges from reset release to the pulse, red channel only.
        wait_pulse(edges, seen);
        check_eq("cycle1_len", edges + 1, 137);
        check_eq("cycle1_pwm_bits", seen, 3'b001);
        check_eq("cycle1_busy", busy, 1);

        wait_pulse(edges, seen);
        check_eq("cycle2_len", edges, CycleLen);
        check_eq("cycle2_pwm_bits", seen, 3'b010);

        wait_pulse(edges, seen);
        check_eq("cycle3_len", edges, CycleLen);
        check_eq("cycle3_pwm_bits", seen, 3'b100);

        // Cycle 4 wraps to bit0; en drops during fade-in and the cycle completes.
        seen_pre = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen_pre |= pwm;
        end
        en = 1'b0;
        wait_pulse(edges, seen);
        check_eq("cycle4_len", edges + 10, CycleLen);
        check_eq("cycle4_pwm_bits", seen | seen_pre, 3'b001);
        check_eq("stop_busy", busy, 0);

        cnt_pwm  = 0;
        cnt_busy = 0;
        cnt_done = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (pwm != 3'b000) cnt_pwm++;
            if (busy) cnt_busy++;
            if (cycle_done) cnt_done++;
        end
        check_eq("idle_pwm_cycles", cnt_pwm, 0);
        check_eq("idle_busy_cycles", cnt_busy, 0);
        check_eq("idle_extra_pulses", cnt_done, 0);
        check_eq("stop_rgb", dut.rgb_q, 3'b010);

        // Restart and reset in the middle of HOLD (edges 64..71 after start).
        en = 1'b1;
        step();
        repeat (65) step();
        check_eq("hold_busy", busy, 1);
        check_eq("hold_level", dut.level_q, 15);
        check_eq("hold_rgb", dut.rgb_q, 3'b010);
        rst_n = 1'b0;
        en    = 1'b0;
        step();
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_pwm", pwm, 0);
        check_eq("midrst_level", dut.level_q, 0);
        check_eq("midrst_rgb", dut.rgb_q, 3'b001);
        check_eq("midrst_cycle_done", cycle_done, 0);
        rst_n = 1'b1;

        cnt_pwm  = 0;
        cnt_busy = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (pwm != 3'b000) cnt_pwm++;
            if (busy) cnt_busy++;
        end
        check_eq("postrst_pwm_cycles", cnt_pwm, 0);
        check_eq("postrst_busy_cycles", cnt_busy, 0);

        // Full-brightness duty on the long-hold instance: level 15 spans
        // edges ~61..132 after start; sample one 16-cycle PWM period inside it.
        en_h = 1'b1;
        repeat (80) step();
        check_eq("hold_inst_busy", busy_h, 1);
        cnt_hi    = 0;
        cnt_other = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (pwm_h[0]) cnt_hi++;
            if (pwm_h[2:1] != 2'b00) cnt_other++;
        end
        check_eq("hold_duty", cnt_hi, HoldDuty);
        check_eq("hold_other_bits", cnt_other, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rgb_fade_sequencer.md
# rgb_fade_sequencer

Fading colour sequencer for the on-chip RGB LED driver. Generates the three PWM enables that feed the current-mode RGB driver's RGB0PWM/RGB1PWM/RGB2PWM inputs: each colour channel fades in, holds and fades out, then the active colour rotates. It sits between the internal high-frequency oscillator and the RGB driver instance, replacing a fixed on/off blink with brightness sequencing.

## Interface
Parameters:
- step_cycles, 187_500: clock cycles per brightness step (≈1 s fade at 48 MHz, 8-bit).
- hold_steps, 256: steps spent at full brightness; ≥1.
- pwm_bits, 8: width of PWM counter and brightness level; max level L = 2^pwm_bits − 1.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  run request; level-sensitive.
- pwm  out  3  PWM enables; bit0→RGB0PWM, bit1→RGB1PWM, bit2→RGB2PWM.
- busy  out  1  high whenever state ≠ IDLE.
- cycle_done  out  1  one-cycle pulse at end of each fade-out.

## Operation
- Registers: pwm_cnt (pwm_bits), presc (clog2(step_cycles)), level (pwm_bits), hold_cnt (clog2(hold_steps)), rgb (3, one-hot), state.
- Reset (rst_n=0 at clk edge): state=IDLE, rgb=3'b001, level=0, pwm_cnt=0, presc=0, hold_cnt=0, pwm=0, busy=0, cycle_done=0. Reset mid-fade takes effect immediately; no graceful completion.
- pwm_cnt: free-running +1 every cycle, wraps L→0, including in IDLE.
- Prescaler: held at 0 in IDLE. Otherwise tick=1 when presc==step_cycles−1, then presc←0; else presc+1.
- FSM:
  - IDLE: level=0. en=1 → FADE_IN next cycle.
  - FADE_IN: on tick, level==L → HOLD (hold_cnt←0); else level+1.
  - HOLD: on tick, hold_cnt==hold_steps−1 → FADE_OUT; else hold_cnt+1.
  - FADE_OUT: on tick, level==0 → end of cycle; else level−1.
  - End of cycle: rgb←{rgb[1:0],rgb[2]}, cycle_done=1 for one cycle, next state FADE_IN if en=1 else IDLE.
- en deasserted outside IDLE does not abort; current cycle completes through FADE_OUT, then IDLE. en sampled only in IDLE and at end of cycle.
- duty = level, or gamma-corrected (see Configuration).
- pwm ← rgb & {3{pwm_cnt < duty}}, registered. duty=0 → always off; duty=L → on L of 2^pwm_bits cycles.
- Exactly one pwm bit can be high at a time.

## Timing
- IDLE→FADE_IN: 1 cycle after first edge with en=1; busy rises same edge.
- Per cycle: 2^pwm_bits ticks fade-in + hold_steps ticks hold + 2^pwm_bits ticks fade-out; duration = step_cycles·(2^(pwm_bits+1)+hold_steps) clocks.
- pwm lags pwm_cnt/duty by 1 cycle (2 with gamma).
- cycle_done asserted on the cycle following the final FADE_OUT tick, coincident with rgb rotation and state change.
- rgb sequence: 001→010→100→001, wraps indefinitely.

## Configuration
- RGB_FADE_GAMMA_EN defined: duty_g = (level·level) >> pwm_bits, computed in one extra register stage; pwm then lags level by 2 cycles. Level 0→0, L→L−1 (L=255: 254).
- Undefined: duty = level, no multiplier, 1-cycle lag. FSM timing identical either way.

## Test plan
Bench parameters step_cycles=4, hold_steps=2, pwm_bits=4 (L=15) unless noted.
- Reset: rst_n=0 for 3 cycles with en=1 → pwm=0, busy=0, cycle_done=0; one cycle after rst_n=1, busy=1.
- Full cycle: en=1 held → cycle_done pulse 1+4·(16+2+16)=137 cycles after en sampled; pwm bit0 only during cycle, next cycle uses bit1, then bit2, then bit0.
- Duty: force level=15 in HOLD (no gamma) → pwm[0] high 15 of every 16 cycles; level=0 in IDLE → pwm=0 permanently.
- Graceful stop: drop en during FADE_IN → fade completes, cycle_done pulses once, state IDLE, busy=0, rgb=3'b010.
- Reset mid-HOLD: rst_n=0 one cycle → next cycle level=0, rgb=3'b001, pwm=0, state IDLE.
- Gamma (RGB_FADE_GAMMA_EN, pwm_bits=8): level=128 → duty 64, pwm high 64 of 256 cycles; level=255 → 254 of 256.
